// File: rtl/sd_cmd_framer_if.sv
// sd_cmd_framer_if
// Bundles the request side (start, cmd_idx, cmd_arg) and the transmitter
// side (tx_oe, tx_load, tx_byte) of the SD command framer, together with
// its status outputs (busy, done, crc_out).
//   master : drives the request, observes transmitter feed and status
//   slave  : the framer itself
interface sd_cmd_framer_if;
  logic        start;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        tx_oe;
  logic        tx_load;
  logic [7:0]  tx_byte;
  logic        busy;
  logic        done;
  logic [6:0]  crc_out;

  modport master (
    output start, cmd_idx, cmd_arg,
    input  tx_oe, tx_load, tx_byte, busy, done, crc_out
  );

  modport slave (
    input  start, cmd_idx, cmd_arg,
    output tx_oe, tx_load, tx_byte, busy, done, crc_out
  );
endinterface

// File: rtl/sd_cmd_framer.sv
// sd_cmd_framer
// Builds a 48-bit SD command frame {01, cmd_idx, cmd_arg, crc7, 1} and feeds
// it to the CMD line transmitter one byte every 8 clocks (tx_load pulse with
// the byte on tx_byte, tx_oe held high). CRC7 (x^7+x^3+1) is accumulated one
// bit per clock during the first 40 frame cycles, so the final byte can carry
// it without extra latency. After the frame, tx_oe stays high for TAIL_CYCLES
// clocks so the transmitter refills with ones; done pulses on the last one.
// Ports:
//   clk   : clock, state changes on posedge (transmitter samples on negedge)
//   reset : asynchronous, active-high
//   bus   : sd_cmd_framer_if.slave (start/cmd_idx/cmd_arg in,
//           tx_oe/tx_load/tx_byte/busy/done/crc_out out)
module sd_cmd_framer #(
  parameter int TAIL_CYCLES = 8
) (
  input logic             clk,
  input logic             reset,
  sd_cmd_framer_if.slave  bus
);

  localparam logic [7:0] TAIL_LAST = 8'(TAIL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    TAIL
  } state_t;

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [7:0]  tail_cnt;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [6:0]  crc;

  logic [39:0] frame_bits;
  logic        cur_bit;
  logic        fb;
  logic [6:0]  crc_next;
  logic [7:0]  next_byte;

  assign frame_bits = {2'b01, idx_q, arg_q};

  // CRC step for the frame bit of the current cycle. Bit c of the frame is
  // frame_bits[39-c]; beyond the CRC-covered region the value is unused.
  always_comb begin
    cur_bit  = 1'b1;
    if (bit_cnt < 6'd40) begin
      cur_bit = frame_bits[6'd39 - bit_cnt];
    end
    fb       = cur_bit ^ crc[6];
    crc_next = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  end

  // Byte to present at the next load. It is selected one cycle early
  // (when bit_cnt[2:0]==7) because outputs are registered; for the last
  // byte this uses crc_next, which already includes frame bit 39.
  always_comb begin
    next_byte = 8'hFF;
    case (bit_cnt[5:3])
      3'd0:    next_byte = arg_q[31:24];
      3'd1:    next_byte = arg_q[23:16];
      3'd2:    next_byte = arg_q[15:8];
      3'd3:    next_byte = arg_q[7:0];
      3'd4:    next_byte = {crc_next, 1'b1};
      default: next_byte = 8'hFF;
    endcase
  end

  // Main FSM. All transmitter-facing outputs are registered here so they
  // settle right after posedge, well before the transmitter's negedge sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 6'd0;
      tail_cnt    <= 8'd0;
      idx_q       <= 6'd0;
      arg_q       <= 32'd0;
      crc         <= 7'd0;
      bus.tx_oe   <= 1'b0;
      bus.tx_load <= 1'b0;
      bus.tx_byte <= 8'hFF;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.crc_out <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.tx_oe   <= 1'b0;
          bus.tx_load <= 1'b0;
          bus.tx_byte <= 8'hFF;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
          if (bus.start) begin
            idx_q       <= bus.cmd_idx;
            arg_q       <= bus.cmd_arg;
            crc         <= 7'd0;
            bit_cnt     <= 6'd0;
            state       <= FRAME;
            bus.tx_oe   <= 1'b1;
            bus.busy    <= 1'b1;
            bus.tx_load <= 1'b1;
            bus.tx_byte <= {2'b01, bus.cmd_idx};
          end
        end

        FRAME: begin
          if (bit_cnt < 6'd40) begin
            crc <= crc_next;
          end
          // crc holds the finished CRC throughout cycle 40
          if (bit_cnt == 6'd40) begin
            bus.crc_out <= crc;
          end
          if (bit_cnt == 6'd47) begin
            state       <= TAIL;
            tail_cnt    <= 8'd0;
            bus.tx_load <= 1'b0;
            bus.tx_byte <= 8'hFF;
            bus.done    <= (TAIL_LAST == 8'd0);
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt[2:0] == 3'd7) begin
              bus.tx_load <= 1'b1;
              bus.tx_byte <= next_byte;
            end else begin
              bus.tx_load <= 1'b0;
              bus.tx_byte <= 8'hFF;
            end
          end
        end

        TAIL: begin
          if (tail_cnt == TAIL_LAST) begin
            state     <= IDLE;
            bus.tx_oe <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
          end else begin
            tail_cnt <= tail_cnt + 8'd1;
            bus.done <= ((tail_cnt + 8'd1) == TAIL_LAST);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sd_cmd_framer.md
Name: sd_cmd_framer

Overview:
Upstream stage of the CMD line transmitter. It builds a 48-bit SD command frame from a command index and a 32-bit argument. It computes CRC7 serially while the frame is being sent, and feeds the transmitter one byte every 8 clocks through that block's oe/load/romdata interface. The transmitter's muxl/muxh inputs are tied low at integration, so every frame byte reaches it through romdata.

Parameters:
TAIL_CYCLES, 8, clocks of extra oe=1/load=0 after the last frame bit so the transmitter shift register refills with 1s (line idles high). Legal range 1..255.

Ports:
clk  input  1  clock; state updates on posedge. The transmitter samples on negedge.
reset  input  1  reset, asynchronous, active-high.
start  input  1  request a frame; sampled on posedge only while idle.
cmd_idx  input  6  command index, captured on accepted start.
cmd_arg  input  32  argument, captured on accepted start.
tx_oe  output  1  to transmitter oe.
tx_load  output  1  to transmitter load.
tx_byte  output  8  to transmitter romdata.
busy  output  1  high from the cycle after start is accepted until return to IDLE.
done  output  1  one-cycle pulse on the final TAIL cycle.
crc_out  output  7  CRC7 of the last frame; valid from cycle 40 onward, held until the next start.

Behaviour:
- Reset (async): state=IDLE. tx_oe=0, tx_load=0, tx_byte=8'hFF, busy=0, done=0, crc_out=0, bit counter=0. A reset mid-frame aborts immediately; no partial completion and no done pulse.
- States: IDLE -> FRAME -> TAIL -> IDLE.
- IDLE:
  - All outputs at reset values; crc_out holds its last value.
  - start=1 at a posedge: capture cmd_idx/cmd_arg, clear CRC and bit counter c, go to FRAME.
- Frame bytes, MSB first:
  - B0 = {2'b01, cmd_idx}
  - B1..B4 = cmd_arg[31:24], [23:16], [15:8], [7:0]
  - B5 = {crc7, 1'b1}
- FRAME, cycle c = 0..47 (c counts posedge cycles after entry):
  - tx_oe=1, busy=1.
  - tx_load=1 iff c[2:0]==0. tx_byte=B[c>>3] when tx_load=1, else 8'hFF.
  - Outputs are decoded from registered state only, so they are stable before the negedge at which the transmitter samples them.
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0.
  - In cycle c = 0..39, frame bit c (bit 7-(c%8) of B[c>>3]) is shifted into the CRC at the end-of-cycle posedge.
  - fb = bit ^ crc[6]; crc <= {crc[5:3], crc[2]^fb, crc[1:0], fb}.
  - The CRC is complete at the start of cycle 40, exactly when B5 is loaded. No extra latency.
  - crc_out is registered at the end of cycle 40.
- Frame-to-TAIL: after cycle 47, go to TAIL. The transmitter has shifted out the end bit by the negedge in cycle 47.
- TAIL: tx_oe=1, tx_load=0, busy=1 for TAIL_CYCLES cycles. done=1 on the last of them, then IDLE.
- start while busy: ignored, with no queuing. cmd_idx/cmd_arg changes while busy have no effect (captured copy is used).
- start asserted in the same cycle done=1: ignored. The earliest accepted start is the first cycle in IDLE.
- Total latency: start accepted at posedge T, first load at cycle T+1, done at cycle T+48+TAIL_CYCLES. With the default, back-to-back frames are 57 cycles apart.
- Bit counter is 6 bits in FRAME; TAIL uses a separate 8-bit counter.

Test Plan:
1. Reset, then start with idx=0, arg=0 -> tx_load pulses at c=0,8,...,40; tx_byte sequence 40 00 00 00 00 95; crc_out=0x4A. Serial CMD line from transmitter model = 0x400000000095 MSB first, then 8 ones.
2. idx=8, arg=0x000001AA -> bytes 48 00 00 01 AA 87, crc_out=0x43. idx=17, arg=0 -> 51 00 00 00 00 55.
3. Pulse start again at c=10 and during TAIL -> ignored; frame bytes unchanged; exactly one done pulse, at the cycle 56 cycles after acceptance.
4. Change cmd_arg to 0xFFFFFFFF at c=5 -> emitted bytes still match the captured arg; CRC matches the captured frame.
5. Assert reset at c=20 -> same cycle tx_oe=0, busy=0, tx_byte=FF; no done. Next start produces a clean correct frame (idx=55, arg=0 -> 77 00 00 00 00 65).
6. TAIL_CYCLES=1 instance: done at T+49. Start held continuously high -> new frame accepted on the first IDLE cycle, 50 cycles apart.
